// File: rtl/mio_bus_arbiter_pkg.sv
// Shared definitions for the MIO bus arbiter: FSM state encoding and master IDs.
package mio_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic MASTER_CPU = 1'b0;
  localparam logic MASTER_DMA = 1'b1;

endpackage

// File: rtl/mio_rr_picker.sv
// Two-way round-robin picker: on contention the master that did not win last time is chosen.
module mio_rr_picker
  import mio_bus_arbiter_pkg::*;
(
  input  logic cpu_req,
  input  logic dma_req,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_id
);

  always_comb begin
    grant_valid = cpu_req | dma_req;
    grant_id    = MASTER_CPU;
    if (cpu_req && dma_req) begin
      grant_id = (last_grant == MASTER_CPU) ? MASTER_DMA : MASTER_CPU;
    end else if (dma_req) begin
      grant_id = MASTER_DMA;
    end
  end

endmodule

// File: rtl/mio_bus_arbiter.sv
// Shares the MIO bus between the CPU and a DMA requester: one access at a time,
// fixed wait states, one-cycle ready pulse back to the winning master.
module mio_bus_arbiter
  import mio_bus_arbiter_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int AW          = 32,
  parameter int DW          = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ready,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_ready,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          owner
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t        state_q, state_d;
  logic [3:0]    cnt_q;
  logic          last_grant_q;
  logic          owner_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] cpu_rdata_q, dma_rdata_q;
  logic          grant_valid, grant_id;

  mio_rr_picker u_picker (
    .cpu_req     (cpu_req),
    .dma_req     (dma_req),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (grant_valid) state_d = ST_ACCESS;
      ST_ACCESS: if (cnt_q == 4'd0) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Grant latch in IDLE; wait countdown and read capture in ACCESS
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q        <= 4'd0;
      last_grant_q <= MASTER_DMA;
      owner_q      <= MASTER_CPU;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_valid) begin
            owner_q <= grant_id;
            cnt_q   <= WAIT_INIT;
            if (grant_id == MASTER_DMA) begin
              we_q    <= dma_we;
              addr_q  <= dma_addr;
              wdata_q <= dma_wdata;
            end else begin
              we_q    <= cpu_we;
              addr_q  <= cpu_addr;
              wdata_q <= cpu_wdata;
            end
          end
        end
        ST_ACCESS: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            last_grant_q <= owner_q;
            if (!we_q) begin
              if (owner_q == MASTER_DMA) dma_rdata_q <= mem_rdata;
              else                       cpu_rdata_q <= mem_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Strobes decode straight from state so an async reset drops them at once
  assign mem_en    = (state_q == ST_ACCESS);
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign owner     = owner_q;
  assign cpu_ready = (state_q == ST_DONE) && (owner_q == MASTER_CPU);
  assign dma_ready = (state_q == ST_DONE) && (owner_q == MASTER_DMA);
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;

endmodule

// File: tb/tb_mio_bus_arbiter.sv
// Bench for mio_bus_arbiter: directed literal checks plus randomized traffic against a
// schedule-based reference model (grant cycle -> bus window -> ready cycle).
module tb_mio_bus_arbiter;

  localparam int W = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 0, cpu_we = 0, dma_req = 0, dma_we = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0, dma_addr = 0, dma_wdata = 0, mem_rdata = 0;
  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;
  logic        cpu_ready, dma_ready, mem_en, mem_we, owner;

  // second instance with zero wait states
  logic        z_dma_req = 0, z_dma_we = 0;
  logic [31:0] z_dma_addr = 0, z_dma_wdata = 0;
  logic [31:0] z_cpu_rdata, z_dma_rdata, z_mem_addr, z_mem_wdata;
  logic        z_cpu_ready, z_dma_ready, z_mem_en, z_mem_we, z_owner;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mio_bus_arbiter #(.WAIT_CYCLES(W), .AW(32), .DW(32)) u_dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ready(dma_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .owner(owner)
  );

  mio_bus_arbiter #(.WAIT_CYCLES(0), .AW(32), .DW(32)) u_dut0 (
    .clk(clk), .reset(reset),
    .cpu_req(1'b0), .cpu_we(1'b0), .cpu_addr(32'h0), .cpu_wdata(32'h0),
    .cpu_rdata(z_cpu_rdata), .cpu_ready(z_cpu_ready),
    .dma_req(z_dma_req), .dma_we(z_dma_we), .dma_addr(z_dma_addr), .dma_wdata(z_dma_wdata),
    .dma_rdata(z_dma_rdata), .dma_ready(z_dma_ready),
    .mem_en(z_mem_en), .mem_we(z_mem_we), .mem_addr(z_mem_addr), .mem_wdata(z_mem_wdata),
    .mem_rdata(32'hFFFF_FFFF), .owner(z_owner)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each access is a schedule of absolute cycle numbers.
  int          cyc = 0;
  int          m_free = 0, m_start = 0, m_end = 0, m_rdy = 0;
  bit          m_have = 0;
  logic        m_win = 0, m_last = 1, m_owner = 0, m_we = 0;
  logic [31:0] m_addr = 0, m_wdata = 0;
  logic [31:0] m_rdata [2] = '{32'h0, 32'h0};

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_have = 0; m_free = 0; m_last = 1; m_owner = 0; m_we = 0;
      m_addr = 0; m_wdata = 0; m_rdata[0] = 0; m_rdata[1] = 0;
    end else begin
      if (m_have && cyc == m_end) begin
        if (!m_we) m_rdata[m_win] = mem_rdata;
        m_last = m_win;
      end
      if (cyc >= m_free && (cpu_req || dma_req)) begin
        m_win   = (cpu_req && dma_req) ? ~m_last : dma_req;
        m_owner = m_win;
        m_we    = m_win ? dma_we : cpu_we;
        m_addr  = m_win ? dma_addr : cpu_addr;
        m_wdata = m_win ? dma_wdata : cpu_wdata;
        m_start = cyc + 1;
        m_end   = cyc + 1 + W;
        m_rdy   = cyc + 2 + W;
        m_free  = cyc + 3 + W;
        m_have  = 1;
      end
      cyc = cyc + 1;
    end
  end

  always @(negedge clk) begin
    logic e_en, e_rdy;
    e_en  = m_have && cyc >= m_start && cyc <= m_end;
    e_rdy = m_have && cyc == m_rdy;
    check("mem_en", {31'd0, mem_en}, {31'd0, e_en});
    check("mem_we", {31'd0, mem_we}, {31'd0, e_en & m_we});
    check("mem_addr", mem_addr, m_addr);
    check("mem_wdata", mem_wdata, m_wdata);
    check("owner", {31'd0, owner}, {31'd0, m_owner});
    check("cpu_ready", {31'd0, cpu_ready}, {31'd0, e_rdy & ~m_win});
    check("dma_ready", {31'd0, dma_ready}, {31'd0, e_rdy & m_win});
    check("cpu_rdata", cpu_rdata, m_rdata[0]);
    check("dma_rdata", dma_rdata, m_rdata[1]);
    check("one_ready", {31'd0, cpu_ready & dma_ready}, 32'd0);
  end

  initial begin
    int   rdy_cnt, rises;
    logic prev_en;
    logic grants [$];

    repeat (3) @(negedge clk);
    check("rst_mem_en", {31'd0, mem_en}, 32'd0);
    check("rst_owner", {31'd0, owner}, 32'd0);
    check("rst_rdata", cpu_rdata, 32'd0);
    reset = 0;

    // CPU read with one wait state
    @(posedge clk); #1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0000_0010; mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk); check("t1_idle_en", {31'd0, mem_en}, 32'd0);
    @(negedge clk); check("t1_en1", {31'd0, mem_en}, 32'd1);
    check("t1_addr", mem_addr, 32'h0000_0010);
    @(negedge clk); check("t1_en2", {31'd0, mem_en}, 32'd1);
    @(negedge clk); check("t1_ready", {31'd0, cpu_ready}, 32'd1);
    check("t1_en_off", {31'd0, mem_en}, 32'd0);
    check("t1_rdata", cpu_rdata, 32'hDEAD_BEEF);
    cpu_req = 0;
    @(negedge clk); check("t1_ready_gone", {31'd0, cpu_ready}, 32'd0);

    // DMA write on the zero-wait instance
    @(posedge clk); #1;
    z_dma_req = 1; z_dma_we = 1; z_dma_addr = 32'h0000_2000; z_dma_wdata = 32'h1234_5678;
    @(negedge clk); check("t3_idle_en", {31'd0, z_mem_en}, 32'd0);
    @(negedge clk); check("t3_en", {31'd0, z_mem_en}, 32'd1);
    check("t3_we", {31'd0, z_mem_we}, 32'd1);
    check("t3_addr", z_mem_addr, 32'h0000_2000);
    check("t3_wdata", z_mem_wdata, 32'h1234_5678);
    @(negedge clk); check("t3_en_off", {31'd0, z_mem_en}, 32'd0);
    check("t3_ready", {31'd0, z_dma_ready}, 32'd1);
    check("t3_rdata", z_dma_rdata, 32'h0);
    check("t3_owner", {31'd0, z_owner}, 32'd1);
    z_dma_req = 0;

    // Ties from reset release: strict alternation starting with CPU
    @(posedge clk); #1;
    reset = 1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h100;
    dma_req = 1; dma_we = 0; dma_addr = 32'h200;
    @(negedge clk); reset = 0;
    rdy_cnt = 0; prev_en = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (mem_en && !prev_en) grants.push_back(owner);
      prev_en = mem_en;
      if (cpu_ready || dma_ready) begin
        rdy_cnt++;
        if (rdy_cnt == 6) begin cpu_req = 0; dma_req = 0; break; end
      end
    end
    check("t4_ready_count", rdy_cnt, 6);
    check("t4_grant_count", grants.size(), 6);
    for (int i = 0; i < grants.size() && i < 6; i++)
      check($sformatf("t4_grant%0d", i), {31'd0, grants[i]}, (i % 2 == 0) ? 32'd0 : 32'd1);

    // Reset in the middle of an access
    @(posedge clk); #1; cpu_req = 1; cpu_we = 0; cpu_addr = 32'h30;
    @(posedge clk); #1; check("t5_en_before", {31'd0, mem_en}, 32'd1);
    #1 reset = 1;
    #1 check("t5_en_async", {31'd0, mem_en}, 32'd0);
    cpu_req = 0;
    @(negedge clk); check("t5_no_ready", {31'd0, cpu_ready}, 32'd0);
    @(negedge clk); reset = 0;
    check("t5_owner", {31'd0, owner}, 32'd0);
    rises = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rises += int'(cpu_ready | dma_ready | mem_en);
    end
    check("t5_quiet", rises, 0);

    // CPU drops request while the access is on the bus
    @(posedge clk); #1; cpu_req = 1; cpu_we = 1; cpu_addr = 32'h40; cpu_wdata = 32'hA5A5_A5A5;
    @(posedge clk); #1; cpu_req = 0;
    rdy_cnt = 0; rises = 0; prev_en = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (mem_en && !prev_en) rises++;
      prev_en = mem_en;
      rdy_cnt += int'(cpu_ready);
    end
    check("t6_ready_once", rdy_cnt, 1);
    check("t6_one_access", rises, 1);

    // Randomized traffic, checked every cycle by the model
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (i == 1500) begin
        #2 reset = 1;
        @(posedge clk); #3 reset = 0;
      end
      if (!cpu_req || cpu_ready) begin
        cpu_req   = ($urandom_range(0, 2) != 0);
        cpu_we    = $urandom_range(0, 1);
        cpu_addr  = $urandom;
        cpu_wdata = $urandom;
      end else if ($urandom_range(0, 31) == 0) cpu_req = 0;
      if (!dma_req || dma_ready) begin
        dma_req   = ($urandom_range(0, 2) != 0);
        dma_we    = $urandom_range(0, 1);
        dma_addr  = $urandom;
        dma_wdata = $urandom;
      end else if ($urandom_range(0, 31) == 0) dma_req = 0;
      mem_rdata = $urandom;
    end
    cpu_req = 0; dma_req = 0;
    repeat (8) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
